// File: rtl/iddr_deser.sv
// DDR receive deserializer: packs captured bit pairs MSB-first into OW-bit words,
// realigning the word boundary by manual slip or by hunting for a sync word.
module iddr_deser #(
    parameter int unsigned   OW   = 8,
    parameter logic [OW-1:0] SYNC = OW'('hA5)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_en,
    input  logic [1:0]    i_ddr,
    input  logic          i_slip,
    input  logic          i_hunt,
    output logic          o_valid,
    output logic [OW-1:0] o_word,
    output logic          o_locked
);
    localparam int unsigned NW = $clog2(OW + 2);

    typedef enum logic {ST_HUNT, ST_LOCK} state_t;

    state_t        state_q, state_d;
    logic [OW-2:0] sreg_q, sreg_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          aslip_q, aslip_d;
    logic          valid_q, valid_d;
    logic [OW-1:0] word_q, word_d;

    logic [OW:0]   sreg_n;
    logic          slip;
    logic          done;
    logic [NW-1:0] n;
    logic [NW-1:0] r;
    logic [OW-1:0] word;

    // The two oldest bits of the OW+1 bit shift buffer are never read after the
    // next shift, so only OW-1 bits are held; sreg_n rebuilds the full view.
    always_comb begin
        sreg_n = {sreg_q, i_ddr};
        slip   = (state_q == ST_LOCK) ? i_slip : aslip_q;
        n      = cnt_q + NW'(2) - NW'(slip);
        done   = (n >= NW'(OW));
        r      = n - NW'(OW);
        word   = r[0] ? sreg_n[OW:1] : sreg_n[OW-1:0];
    end

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        aslip_d = aslip_q;
        valid_d = 1'b0;
        word_d  = word_q;
        if (i_en) begin
            sreg_d = sreg_n[OW-2:0];
            cnt_d  = done ? r : n;
            if (state_q == ST_HUNT) begin
                if (slip) begin
                    aslip_d = 1'b0;
                end
                if (done) begin
                    if (word == SYNC) begin
                        state_d = ST_LOCK;
                    end else begin
                        aslip_d = 1'b1;
                    end
                end
            end else if (done) begin
                valid_d = 1'b1;
                word_d  = word;
            end
        end
        // A hunt request overrides both a sync match and a LOCK-state emission.
        if (i_hunt) begin
            state_d = ST_HUNT;
            aslip_d = 1'b0;
            valid_d = 1'b0;
            word_d  = word_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_HUNT;
            sreg_q  <= '0;
            cnt_q   <= '0;
            aslip_q <= 1'b0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            aslip_q <= aslip_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_word   = word_q;
    assign o_locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_iddr_deser.sv
// Directed bench for iddr_deser: expected words are queued with the cycle they
// are due and compared against o_valid/o_word at every sampled clock.
module tb_iddr_deser;
    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_en;
    logic [1:0] i_ddr;
    logic       i_slip;
    logic       i_hunt;
    logic       o_valid;
    logic [7:0] o_word;
    logic       o_locked;

    iddr_deser #(.OW(8), .SYNC(8'hA5)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_en),
        .i_ddr     (i_ddr),
        .i_slip    (i_slip),
        .i_hunt    (i_hunt),
        .o_valid   (o_valid),
        .o_word    (o_word),
        .o_locked  (o_locked)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int unsigned due;
        logic [7:0]  w;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned nvec;
    int unsigned nmis;
    bit          gaps_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock with the current inputs, then check strobe/word against the scoreboard.
    task automatic step();
        logic pending;
        exp_t e;
        cyc++;
        @(posedge i_clk);
        #1;
        pending = (sb.size() > 0) && (sb[0].due == cyc);
        chk("valid_strobe", {31'd0, o_valid}, {31'd0, pending});
        if (pending) begin
            e = sb.pop_front();
            chk("word", {24'd0, o_word}, {24'd0, e.w});
        end
    endtask

    task automatic pr(input logic b1, input logic b0, input logic slip,
                      input logic hunt, input logic push, input logic [7:0] w);
        int unsigned ngap;
        if (gaps_on) begin
            ngap = $urandom_range(0, 2);
            for (int unsigned k = 0; k < ngap; k++) begin
                i_en   = 1'b0;
                i_ddr  = 2'($urandom);
                i_slip = 1'($urandom);
                i_hunt = 1'b0;
                step();
            end
        end
        if (push) sb.push_back('{due: cyc + 1, w: w});
        i_en   = 1'b1;
        i_ddr  = {b1, b0};
        i_slip = slip;
        i_hunt = hunt;
        step();
        i_en   = 1'b0;
        i_slip = 1'b0;
        i_hunt = 1'b0;
    endtask

    // Word boundary coincides with a pair boundary.
    task automatic send_aligned(input logic [7:0] w, input logic push, input logic hunt_last);
        pr(w[7], w[6], 1'b0, 1'b0, 1'b0, 8'h00);
        pr(w[5], w[4], 1'b0, 1'b0, 1'b0, 8'h00);
        pr(w[3], w[2], 1'b0, 1'b0, 1'b0, 8'h00);
        pr(w[1], w[0], 1'b0, hunt_last, push, w);
    endtask

    // Boundary sits mid-pair: w[7] already went out, nmsb is the next word's MSB.
    task automatic send_r1(input logic [7:0] w, input logic nmsb, input logic push,
                           input logic slip_last, input logic [7:0] ew);
        pr(w[6], w[5], 1'b0, 1'b0, 1'b0, 8'h00);
        pr(w[4], w[3], 1'b0, 1'b0, 1'b0, 8'h00);
        pr(w[2], w[1], 1'b0, 1'b0, 1'b0, 8'h00);
        pr(w[0], nmsb, slip_last, 1'b0, push, ew);
    endtask

    task automatic do_reset();
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("async_rst_valid",  {31'd0, o_valid},  32'd0);
        chk("async_rst_word",   {24'd0, o_word},   32'd0);
        chk("async_rst_locked", {31'd0, o_locked}, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gw [6];
        gw = '{8'h12, 8'h34, 8'hF0, 8'h0F, 8'hAA, 8'h55};
        cyc = 0; nvec = 0; nmis = 0; gaps_on = 1'b0;
        i_reset_n = 1'b0; i_en = 1'b0; i_ddr = 2'b00; i_slip = 1'b0; i_hunt = 1'b0;

        repeat (2) @(negedge i_clk);
        chk("rst_valid",  {31'd0, o_valid},  32'd0);
        chk("rst_word",   {24'd0, o_word},   32'd0);
        chk("rst_locked", {31'd0, o_locked}, 32'd0);
        i_reset_n = 1'b1;

        // Aligned lock on A5, then first strobed word 3C.
        pr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        pr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        pr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("hunt_unlocked", {31'd0, o_locked}, 32'd0);
        pr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("lock_rise", {31'd0, o_locked}, 32'd1);
        send_aligned(8'h3C, 1'b1, 1'b0);
        step();
        chk("word_hold", {24'd0, o_word}, 32'h3C);
        send_aligned(8'h5A, 1'b1, 1'b0);
        send_aligned(8'hC3, 1'b1, 1'b0);

        // Mid-word manual slip: pad bit absorbed, next gap 5 then 4.
        pr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        send_r1(8'h81, 1'b0, 1'b1, 1'b0, 8'h81);
        send_r1(8'h66, 1'b1, 1'b1, 1'b0, 8'h66);

        // Slip on a completing pair: word still emitted, shifted by one bit.
        send_r1(8'h99, 1'b1, 1'b1, 1'b1, 8'h33);
        send_aligned(8'h5A, 1'b1, 1'b0);
        send_aligned(8'hE7, 1'b1, 1'b0);

        // Idle i_en cycles with stray slips must not disturb the words.
        gaps_on = 1'b1;
        foreach (gw[i]) send_aligned(gw[i], 1'b1, 1'b0);
        gaps_on = 1'b0;

        // Hunt on the cycle a SYNC completes in LOCK, then relock.
        send_aligned(8'hA5, 1'b0, 1'b1);
        chk("hunt_unlock", {31'd0, o_locked}, 32'd0);
        send_aligned(8'hA5, 1'b0, 1'b0);
        chk("relock", {31'd0, o_locked}, 32'd1);
        send_aligned(8'h3C, 1'b1, 1'b0);

        // Asynchronous reset mid-word; partial bits must be discarded.
        pr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        pr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        do_reset();
        send_aligned(8'hA5, 1'b0, 1'b0);
        chk("lock_after_reset", {31'd0, o_locked}, 32'd1);
        send_aligned(8'hC3, 1'b1, 1'b0);

        // Odd misalignment: one leading 0 bit, auto-slip finds A5, 3C follows with r=1.
        pr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        do_reset();
        pr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_r1(8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("odd_still_hunting", {31'd0, o_locked}, 32'd0);
        send_r1(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("odd_lock", {31'd0, o_locked}, 32'd1);
        send_r1(8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C);
        send_r1(8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A);
        step();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
